// File: rtl/spi_tx_queue.sv
// spi_tx_queue: TX FIFO plus auto-sequencer feeding spi_shift/spi_clk_gen.
// Each queued word is latched into spi_shift, go is raised, the end of the
// transfer is awaited and the parallel receive word is captured.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   i_push, i_push_dat          enqueue strobe and word
//   o_full, o_empty, o_level    FIFO status
//   o_tx_ovf, i_ovf_clr         sticky push-while-full flag and its clear
//   i_enable                    allow new transfers to start
//   o_latch, o_tx_dat, o_go     load strobes, word and start to spi_shift
//   i_tip, i_rx_dat             transfer-in-progress and receive word
//   o_rx_dat, o_rx_valid        captured receive word and unread flag
//   i_rx_ack, o_rx_ovr          host consume strobe, sticky overrun flag
//   i_irq_clr, o_irq            queue-drained interrupt and its clear
// Build option: define SPI_TXQ_IRQ_EN to enable o_irq; otherwise it is tied 0.
module spi_tx_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level,
    output logic              o_tx_ovf,
    input  logic              i_ovf_clr,
    input  logic              i_enable,
    output logic [3:0]        o_latch,
    output logic [DATA_W-1:0] o_tx_dat,
    output logic              o_go,
    input  logic              i_tip,
    input  logic [DATA_W-1:0] i_rx_dat,
    output logic [DATA_W-1:0] o_rx_dat,
    output logic              o_rx_valid,
    input  logic              i_rx_ack,
    output logic              o_rx_ovr,
    input  logic              i_irq_clr,
    output logic              o_irq
);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, BUSY, DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              latch_q, latch_d;
    logic [DATA_W-1:0] tx_dat_q, tx_dat_d;
    logic              go_q, go_d;
    logic [DATA_W-1:0] rx_dat_q, rx_dat_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              irq_q, irq_d;

    logic push_ok;
    logic pop;
    logic capture;

    // A push into a full queue is dropped even if LOAD frees a slot this cycle.
    assign push_ok = i_push & ~full_q;
    assign pop     = (state_q == LOAD);
    assign capture = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + (push_ok ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        full_d   = (level_d == (AW+1)'(DEPTH));
        empty_d  = (level_d == '0);

        tx_ovf_d = tx_ovf_q;
        if (i_ovf_clr)
            tx_ovf_d = 1'b0;
        if (i_push && full_q)
            tx_ovf_d = 1'b1;

        unique case (state_q)
            IDLE:  if (i_enable && !empty_q && !i_tip) state_d = LOAD;
            LOAD:  state_d = START;
            START: if (i_tip) state_d = BUSY;
            BUSY:  if (!i_tip) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are registered decodes of the state being entered, so they
        // line up exactly with LOAD and START.
        latch_d  = (state_d == LOAD);
        tx_dat_d = latch_d ? mem_q[rd_ptr_q] : '0;
        go_d     = (state_d == START);

        rx_dat_d   = rx_dat_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        if (i_ovf_clr)
            rx_ovr_d = 1'b0;
        if (capture) begin
            rx_dat_d   = i_rx_dat;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !i_rx_ack)
                rx_ovr_d = 1'b1;
        end else if (i_rx_ack) begin
            rx_valid_d = 1'b0;
        end

`ifdef SPI_TXQ_IRQ_EN
        irq_d = irq_q;
        if (i_irq_clr)
            irq_d = 1'b0;
        if (capture && empty_q)
            irq_d = 1'b1;
`else
        irq_d = 1'b0;
`endif
    end

`ifndef SPI_TXQ_IRQ_EN
    logic unused_irq_clr;
    assign unused_irq_clr = i_irq_clr;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= i_push_dat;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_ovf_q   <= 1'b0;
            latch_q    <= 1'b0;
            tx_dat_q   <= '0;
            go_q       <= 1'b0;
            rx_dat_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_ovf_q   <= tx_ovf_d;
            latch_q    <= latch_d;
            tx_dat_q   <= tx_dat_d;
            go_q       <= go_d;
            rx_dat_q   <= rx_dat_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            irq_q      <= irq_d;
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_level    = level_q;
    assign o_tx_ovf   = tx_ovf_q;
    assign o_latch    = {4{latch_q}};
    assign o_tx_dat   = tx_dat_q;
    assign o_go       = go_q;
    assign o_rx_dat   = rx_dat_q;
    assign o_rx_valid = rx_valid_q;
    assign o_rx_ovr   = rx_ovr_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// tb_spi_tx_queue: directed bench for spi_tx_queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spi_tx_queue;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int AW = 3;
`ifdef SPI_TXQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_push;
    logic [DW-1:0] i_push_dat;
    logic          o_full;
    logic          o_empty;
    logic [AW:0]   o_level;
    logic          o_tx_ovf;
    logic          i_ovf_clr;
    logic          i_enable;
    logic [3:0]    o_latch;
    logic [DW-1:0] o_tx_dat;
    logic          o_go;
    logic          i_tip;
    logic [DW-1:0] i_rx_dat;
    logic [DW-1:0] o_rx_dat;
    logic          o_rx_valid;
    logic          i_rx_ack;
    logic          o_rx_ovr;
    logic          i_irq_clr;
    logic          o_irq;

    int n_checks = 0;
    int n_fail = 0;

    spi_tx_queue #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .i_push    (i_push),
        .i_push_dat(i_push_dat),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_level   (o_level),
        .o_tx_ovf  (o_tx_ovf),
        .i_ovf_clr (i_ovf_clr),
        .i_enable  (i_enable),
        .o_latch   (o_latch),
        .o_tx_dat  (o_tx_dat),
        .o_go      (o_go),
        .i_tip     (i_tip),
        .i_rx_dat  (i_rx_dat),
        .o_rx_dat  (o_rx_dat),
        .o_rx_valid(o_rx_valid),
        .i_rx_ack  (i_rx_ack),
        .o_rx_ovr  (o_rx_ovr),
        .i_irq_clr (i_irq_clr),
        .o_irq     (o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        i_push = 1'b1;
        i_push_dat = d;
        tick();
        i_push = 1'b0;
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (o_go !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_go"}, 32'(o_go), 32'd1);
    endtask

    task automatic xfer(input string tag, input logic [DW-1:0] exp_tx,
                        input logic [DW-1:0] rx);
        int n = 0;
        while (o_latch !== 4'hF && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latch"}, 32'(o_latch), 32'hF);
        chk({tag, "_txdat"}, o_tx_dat, exp_tx);
        wait_go(tag);
        i_rx_dat = rx;
        i_tip = 1'b1;
        repeat (5) tick();
        i_tip = 1'b0;
        repeat (2) tick();
    endtask

    task automatic count_latch(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            tick();
            if (o_latch !== 4'h0) hits++;
        end
    endtask

    int hits;

    initial begin
        rst = 1'b1;
        i_push = 1'b0;
        i_push_dat = '0;
        i_ovf_clr = 1'b0;
        i_enable = 1'b0;
        i_tip = 1'b0;
        i_rx_dat = '0;
        i_rx_ack = 1'b0;
        i_irq_clr = 1'b0;
        repeat (2) tick();
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_go", 32'(o_go), 32'd0);
        chk("rst_latch", 32'(o_latch), 32'd0);
        chk("rst_rxv", 32'(o_rx_valid), 32'd0);
        chk("rst_irq", 32'(o_irq), 32'd0);
        rst = 1'b0;
        tick();

        // Single word: latency and tip handshake.
        i_enable = 1'b1;
        push(32'hA5A5_1234);
        chk("t1_n1_latch", 32'(o_latch), 32'h0);
        chk("t1_n1_level", 32'(o_level), 32'd1);
        chk("t1_n1_empty", 32'(o_empty), 32'd0);
        tick();
        chk("t1_n2_latch", 32'(o_latch), 32'hF);
        chk("t1_n2_txdat", o_tx_dat, 32'hA5A5_1234);
        tick();
        chk("t1_n3_go", 32'(o_go), 32'd1);
        chk("t1_n3_latch", 32'(o_latch), 32'h0);
        chk("t1_n3_level", 32'(o_level), 32'd0);
        tick();
        chk("t1_go_held", 32'(o_go), 32'd1);
        i_rx_dat = 32'h0F0F_5AA5;
        i_tip = 1'b1;
        tick();
        chk("t1_go_drop", 32'(o_go), 32'd0);
        repeat (19) tick();
        i_tip = 1'b0;
        tick();
        chk("t1_rxv_done", 32'(o_rx_valid), 32'd0);
        tick();
        chk("t1_rxv", 32'(o_rx_valid), 32'd1);
        chk("t1_rxdat", o_rx_dat, 32'h0F0F_5AA5);
        i_rx_ack = 1'b1;
        tick();
        i_rx_ack = 1'b0;
        chk("t1_ack", 32'(o_rx_valid), 32'd0);

        // Overfill with sequencer disabled, then drain in order.
        i_enable = 1'b0;
        for (int i = 0; i < 9; i++) push(32'h1000_0000 + i);
        chk("t2_level", 32'(o_level), 32'd8);
        chk("t2_full", 32'(o_full), 32'd1);
        chk("t2_txovf", 32'(o_tx_ovf), 32'd1);
        i_enable = 1'b1;
        for (int i = 0; i < 8; i++)
            xfer($sformatf("t2_w%0d", i), 32'h1000_0000 + i,
                 32'h2000_0000 + i);
        chk("t2_rxdat", o_rx_dat, 32'h2000_0007);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("t2_txovf_clr", 32'(o_tx_ovf), 32'd0);
        chk("t2_rxovr_clr", 32'(o_rx_ovr), 32'd0);
        count_latch(30, hits);
        chk("t2_no_ninth", 32'(hits), 32'd0);
        chk("t2_empty", 32'(o_empty), 32'd1);

        // Receive overrun, then capture coinciding with ack.
        i_rx_ack = 1'b1;
        tick();
        i_rx_ack = 1'b0;
        push(32'hB000_0001);
        push(32'hB000_0002);
        xfer("t3_a", 32'hB000_0001, 32'hC000_0001);
        chk("t3_a_rxv", 32'(o_rx_valid), 32'd1);
        chk("t3_a_ovr", 32'(o_rx_ovr), 32'd0);
        xfer("t3_b", 32'hB000_0002, 32'hC000_0002);
        chk("t3_b_ovr", 32'(o_rx_ovr), 32'd1);
        chk("t3_b_rxdat", o_rx_dat, 32'hC000_0002);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("t3_ovr_clr", 32'(o_rx_ovr), 32'd0);
        push(32'hB000_0003);
        i_rx_ack = 1'b1;
        xfer("t3_c", 32'hB000_0003, 32'hC000_0003);
        i_rx_ack = 1'b0;
        chk("t3_c_rxv", 32'(o_rx_valid), 32'd1);
        chk("t3_c_ovr", 32'(o_rx_ovr), 32'd0);
        chk("t3_c_rxdat", o_rx_dat, 32'hC000_0003);

        // Disable during BUSY with three queued; then drain for the irq.
        i_rx_ack = 1'b1;
        i_irq_clr = 1'b1;
        tick();
        i_rx_ack = 1'b0;
        i_irq_clr = 1'b0;
        chk("t4_irq_clr0", 32'(o_irq), 32'd0);
        i_enable = 1'b0;
        push(32'hD000_0001);
        push(32'hD000_0002);
        push(32'hD000_0003);
        i_enable = 1'b1;
        wait_go("t4");
        i_rx_dat = 32'hE000_0001;
        i_tip = 1'b1;
        tick();
        i_enable = 1'b0;
        repeat (4) tick();
        i_tip = 1'b0;
        repeat (2) tick();
        chk("t4_rxv", 32'(o_rx_valid), 32'd1);
        chk("t4_rxdat", o_rx_dat, 32'hE000_0001);
        chk("t4_irq_busy", 32'(o_irq), 32'd0);
        count_latch(10, hits);
        chk("t4_no_load", 32'(hits), 32'd0);
        chk("t4_level", 32'(o_level), 32'd2);
        i_enable = 1'b1;
        xfer("t4_d2", 32'hD000_0002, 32'hE000_0002);
        chk("t4_irq_d2", 32'(o_irq), 32'd0);
        xfer("t4_d3", 32'hD000_0003, 32'hE000_0003);
        chk("t4_irq_d3", 32'(o_irq), 32'(IRQ_ON));
        i_irq_clr = 1'b1;
        tick();
        i_irq_clr = 1'b0;
        chk("t4_irq_clr", 32'(o_irq), 32'd0);

        // Asynchronous reset in START with one word still queued.
        push(32'hF000_0001);
        push(32'hF000_0002);
        wait_go("t5");
        chk("t5_level_pre", 32'(o_level), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_go", 32'(o_go), 32'd0);
        chk("t5_level", 32'(o_level), 32'd0);
        chk("t5_empty", 32'(o_empty), 32'd1);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
